// File: rtl/wisc_pkg.sv
// Shared types for the unified-memory arbiter.
// Build option MEM_ARB_RR_EN (see mem_arb_pick) selects round-robin arbitration.
package wisc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select between fetch (I) and load/store (D).
// MEM_ARB_RR_EN defined: round-robin on conflict (port not granted last wins).
// MEM_ARB_RR_EN undefined: fixed priority, D over I; i_last_grant is ignored.
module mem_arb_pick
    import wisc_pkg::*;
(
    input  logic   i_ireq,
    input  logic   i_dreq,
    input  owner_t i_last_grant,
    output logic   o_grant,
    output owner_t o_winner
);

    // Winner selection; a lone requester always wins
    always_comb begin
        o_grant  = i_ireq | i_dreq;
        o_winner = OWNER_I;
`ifdef MEM_ARB_RR_EN
        if (i_ireq && i_dreq)
            o_winner = (i_last_grant == OWNER_I) ? OWNER_D : OWNER_I;
        else if (i_dreq)
            o_winner = OWNER_D;
`else
        if (i_dreq)
            o_winner = OWNER_D;
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = (i_last_grant == OWNER_D);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between the fetch and
// load/store ports, one transaction at a time (IDLE/ISSUE/WAIT/RESP).
// Build option MEM_ARB_RR_EN: round-robin instead of fixed D-over-I priority.
// The latched owner doubles as the last-grant record: it is written at every
// grant and resets to OWNER_I, so no separate flop is needed.
// MEM_LAT must be >= 1.
module mem_arbiter
    import wisc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        r_state, w_next;
    owner_t            r_owner, w_winner;
    logic              w_grant;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last;

    mem_arb_pick u_pick (
        .i_ireq       (i_req),
        .i_dreq       (d_req),
        .i_last_grant (r_owner),
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    assign w_last = (r_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and strobes
    always_comb begin
        w_next = r_state;
        mem_en = 1'b0;
        mem_wr = 1'b0;
        i_ack  = 1'b0;
        d_ack  = 1'b0;
        busy   = (r_state != IDLE);
        case (r_state)
            IDLE:  if (w_grant) w_next = ISSUE;
            ISSUE: begin
                mem_en = 1'b1;
                mem_wr = r_wr;
                w_next = WAIT;
            end
            WAIT:  if (w_last) w_next = RESP;
            RESP: begin
                i_ack  = (r_owner == OWNER_I);
                d_ack  = (r_owner == OWNER_D);
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant latch, latency counter and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWNER_I;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant) begin
                    r_owner <= w_winner;
                    if (w_winner == OWNER_D) begin
                        r_addr  <= d_addr;
                        r_wr    <= d_wr;
                        r_wdata <= d_wdata;
                    end else begin
                        r_addr  <= i_addr;
                        r_wr    <= 1'b0;
                        r_wdata <= '0;
                    end
                end
                ISSUE: r_cnt <= CNT_W'(MEM_LAT);
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last && !r_wr) begin
                        if (r_owner == OWNER_D) r_d_rdata <= mem_rdata;
                        else                    r_i_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses, a
// negedge monitor pops and compares on every ack. Works for either build of
// MEM_ARB_RR_EN.
module tb_mem_arbiter;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_wr, busy;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory: read data appears LAT cycles after the strobe, junk otherwise
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] dl [0:LAT-1];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dl[k] <= dl[k-1];
        dl[0] <= mem_en ? mem[mem_addr] : 16'($urandom);
        if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = dl[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t i_q[$], d_q[$];
    int   ord_q[$];
    bit   sb_off = 1'b0;
    int   en_cnt = 0, wr_cnt = 0, ack_cnt = 0, last_en_cyc = -1, last_wr_cyc = -1;
    bit   prev_en = 1'b0;
    logic [15:0] d_last = '0;

    // Monitor: pop and compare on every ack, track memory strobes
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (i_ack && d_ack) chk("dual_ack", 1, 0);
            if (i_ack) begin
                ack_cnt++;
                ord_q.push_back(0);
                if (!sb_off) begin
                    if (i_q.size() == 0) chk("i_spurious_ack", 1, 0);
                    else begin
                        e = i_q.pop_front();
                        chk("i_rdata", i_rdata, e.data);
                        if (e.cyc >= 0) chk("i_ack_cycle", cyc, e.cyc);
                    end
                end
            end
            if (d_ack) begin
                ack_cnt++;
                ord_q.push_back(1);
                if (!sb_off) begin
                    if (d_q.size() == 0) chk("d_spurious_ack", 1, 0);
                    else begin
                        e = d_q.pop_front();
                        chk("d_rdata", d_rdata, e.data);
                        if (e.cyc >= 0) chk("d_ack_cycle", cyc, e.cyc);
                    end
                end
            end
            if (mem_en) begin
                en_cnt++;
                last_en_cyc = cyc;
                chk("mem_en_single", prev_en, 0);
            end
            if (mem_wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                chk("mem_wr_with_en", mem_en, 1);
            end
            prev_en = mem_en;
        end else prev_en = 1'b0;
    end

    task automatic wait_ack(input bit is_d);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(is_d ? d_ack : i_ack) && n < 400);
        if (!(is_d ? d_ack : i_ack)) begin
            chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 0, 1);
            if (is_d && d_q.size() > 0) void'(d_q.pop_front());
            if (!is_d && i_q.size() > 0) void'(i_q.pop_front());
        end
    endtask

    // Data-port transaction; lat < 0 means ack cycle is not checked
    task automatic d_op(input logic wr, input logic [15:0] a, input logic [15:0] w,
                        input int lat, output int t0);
        exp_t e;
        d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = w; t0 = cyc;
        e.cyc = (lat < 0) ? -1 : t0 + lat;
        if (wr) begin e.data = d_last; ref_mem[a] = w; end
        else    begin e.data = ref_mem[a]; d_last = ref_mem[a]; end
        d_q.push_back(e);
        wait_ack(1'b1);
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic i_op(input logic [15:0] a, input int lat, output int t0);
        exp_t e;
        i_req = 1'b1; i_addr = a; t0 = cyc;
        e.cyc = (lat < 0) ? -1 : t0 + lat;
        e.data = ref_mem[a];
        i_q.push_back(e);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'(a) ^ 16'h5A5A;
            ref_mem[a] = 16'(a) ^ 16'h5A5A;
        end
        mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        for (int k = 0; k < LAT; k++) dl[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_mem_addr", {mem_addr, mem_wdata}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone load
        d_op(1'b0, 16'h0010, 16'h0, LAT + 2, t0);
        chk("load_en_cycle", last_en_cyc, t0 + 1);
        chk("load_en_count", en_cnt, 1);

        // Store then load back
        d_op(1'b1, 16'h0020, 16'h1234, LAT + 2, t0);
        chk("store_wr_cycle", last_wr_cyc, t0 + 1);
        chk("store_wr_count", wr_cnt, 1);
        d_op(1'b0, 16'h0020, 16'h0, LAT + 2, t0);
        chk("load_no_wr", wr_cnt, 1);

        // Fetch granted, then address changed and request dropped
        i_req = 1'b1; i_addr = 16'h0100; t0 = cyc;
        i_q.push_back('{data: ref_mem[16'h0100], cyc: t0 + LAT + 2});
        repeat (2) begin @(posedge clk); #1; end
        i_addr = 16'h0155; i_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("fetch_addr_held", mem_addr, 16'h0100);
        wait_ack(1'b0);
        @(posedge clk); #1;

        // Simultaneous requests
        fork
            d_op(1'b0, 16'h0010, 16'h0, LAT + 2, t0);
            i_op(16'h0102, 2 * LAT + 5, t1);
        join

        // Both held continuously: grant order
        sb_off = 1'b1;
        ord_q.delete();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1000;
        i_req = 1'b1; i_addr = 16'h0101;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ord_q.size() < 4 && n < 400);
        d_req = 1'b0; i_req = 1'b0;
        chk("hold_grants", ord_q.size(), 4);
        for (int k = 0; k < 4 && k < ord_q.size(); k++) begin
`ifdef MEM_ARB_RR_EN
            chk("rr_order", ord_q[k], (k % 2 == 0) ? 1 : 0);
`else
            chk("fixed_order", ord_q[k], 1);
`endif
        end
        @(posedge clk); #1;
        sb_off = 1'b0;

        // Reset in the middle of a load
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; t0 = cyc;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_rdata", {i_rdata, d_rdata}, 0);
        d_req = 1'b0; d_last = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("midrst_no_ack_busy", busy, 0);
        d_op(1'b0, 16'h0020, 16'h0, LAT + 2, t0);

        // Randomized concurrent traffic
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    automatic int g = $urandom_range(0, 3);
                    automatic int tt;
                    d_op(1'($urandom_range(0, 1)), 16'(16'h1000 + $urandom_range(0, 15)),
                         16'($urandom), -1, tt);
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    automatic int g = $urandom_range(0, 3);
                    automatic int tt;
                    i_op(16'(16'h0100 + $urandom_range(0, 255)), -1, tt);
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
        join

        repeat (4) begin @(posedge clk); #1; end
        chk("end_i_q_empty", i_q.size(), 0);
        chk("end_d_q_empty", d_q.size(), 0);
        chk("end_en_per_txn", en_cnt, ack_cnt + 1);
        chk("end_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
